// File: rtl/uart_pkg.sv
// Shared UART definitions: data width and transmit handshake state type.
// Kept separate so the receive-side FIFO can reuse them.
package uart_pkg;

  localparam int UART_DATA_W = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    GAP  = 2'd2
  } tx_state_t;

endpackage

// File: rtl/sync_fifo_mem.sv
// DEPTH x byte register array: one synchronous write port, one asynchronous read port.
// Contents are not reset; the pointer logic guarantees that unwritten entries are never read.
module sync_fifo_mem
  import uart_pkg::*;
#(
  parameter int DEPTH  = 16,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic                   clk,
  input  logic                   we,
  input  logic [ADDR_W-1:0]      waddr,
  input  logic [UART_DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0]      raddr,
  output logic [UART_DATA_W-1:0] rdata
);

  logic [UART_DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/uart_tx_fifo.sv
// Transmit FIFO in front of the UART core: buffers host bytes and hands them out
// one at a time over send_req/send_ack, reporting fill level and sticky overflow.
//
// Handshake: send_req is held high with tx_byte stable until send_ack is seen high
// at a rising edge; that edge pops the byte. send_ack outside a request is ignored.
module uart_tx_fifo
  import uart_pkg::*;
#(
  parameter int  DEPTH  = 16,
  localparam int ADDR_W = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          wr_en,
  input  logic [7:0]    wr_data,
  output logic          full,
  output logic          empty,
  output logic [ADDR_W:0] count,
  output logic          overflow,
  input  logic          ovf_clr,
  output logic [7:0]    tx_byte,
  output logic          send_req,
  input  logic          send_ack
);

  localparam logic [ADDR_W:0] FULL_CNT = (ADDR_W+1)'(DEPTH);

  tx_state_t              state;
  logic [ADDR_W-1:0]      wr_ptr;
  logic [ADDR_W-1:0]      rd_ptr;
  logic [UART_DATA_W-1:0] rd_data;
  logic                   wr_accept;
  logic                   wr_reject;
  logic                   pop;

  assign full      = (count == FULL_CNT);
  assign empty     = (count == '0);
  // Acceptance uses the pre-edge full flag, so a pop at the same edge never frees room.
  assign wr_accept = wr_en && !full;
  assign wr_reject = wr_en && full;
  assign pop       = (state == REQ) && send_ack;

  sync_fifo_mem #(
    .DEPTH (DEPTH),
    .ADDR_W(ADDR_W)
  ) u_mem (
    .clk  (clk),
    .we   (wr_accept),
    .waddr(wr_ptr),
    .wdata(wr_data),
    .raddr(rd_ptr),
    .rdata(rd_data)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_accept) wr_ptr <= wr_ptr + ADDR_W'(1);
      if (pop)       rd_ptr <= rd_ptr + ADDR_W'(1);
      case ({wr_accept, pop})
        2'b10:   count <= count + (ADDR_W+1)'(1);
        2'b01:   count <= count - (ADDR_W+1)'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      overflow <= 1'b0;
    end else if (wr_reject) begin
      overflow <= 1'b1;
    end else if (ovf_clr) begin
      overflow <= 1'b0;
    end
  end

  // GAP guarantees send_req drops for two cycles between consecutive bytes.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      tx_byte  <= 8'h00;
      send_req <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (!empty) begin
            tx_byte  <= rd_data;
            send_req <= 1'b1;
            state    <= REQ;
          end
        end
        REQ: begin
          if (send_ack) begin
            send_req <= 1'b0;
            state    <= GAP;
          end
        end
        GAP:     state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Self-checking bench for uart_tx_fifo: queue-based reference model compared every
// cycle, plus directed literal expectations for latency, boundaries and ordering.
module tb_uart_tx_fifo;

  localparam int DEPTH = 16;
  localparam int AW    = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic          wr_en = 1'b0;
  logic [7:0]    wr_data = 8'h00;
  logic          ovf_clr = 1'b0;
  logic          send_ack = 1'b0;
  logic          full, empty, overflow, send_req;
  logic [AW:0]   count;
  logic [7:0]    tx_byte;

  uart_tx_fifo #(.DEPTH(DEPTH)) dut (
    .clk     (clk),
    .reset   (reset),
    .wr_en   (wr_en),
    .wr_data (wr_data),
    .full    (full),
    .empty   (empty),
    .count   (count),
    .overflow(overflow),
    .ovf_clr (ovf_clr),
    .tx_byte (tx_byte),
    .send_req(send_req),
    .send_ack(send_ack)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  int n_vec  = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Queue of stored bytes; a request is open while m_req is set; after a pop the
  // line must stay quiet one extra cycle (m_cool) before a new request may start.
  logic [7:0] exp_q[$];
  logic [7:0] out_log[$];
  int         pop_cyc[$];
  logic       m_req  = 1'b0;
  logic [7:0] m_byte = 8'h00;
  logic       m_ovf  = 1'b0;
  int         m_cool = 0;
  int         m_size = 0;
  int         cyc    = 0;
  logic       chk_on = 1'b0;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      exp_q.delete();
      m_req  = 1'b0;
      m_byte = 8'h00;
      m_ovf  = 1'b0;
      m_cool = 0;
    end else begin
      cyc++;
      m_size = exp_q.size();
      if (m_req) begin
        if (send_ack) begin
          out_log.push_back(exp_q.pop_front());
          pop_cyc.push_back(cyc);
          m_req  = 1'b0;
          m_cool = 1;
        end
      end else if (m_cool > 0) begin
        m_cool--;
      end else if (m_size > 0) begin
        m_req  = 1'b1;
        m_byte = exp_q[0];
      end
      if (wr_en && m_size == DEPTH) m_ovf = 1'b1;
      else if (ovf_clr)             m_ovf = 1'b0;
      if (wr_en && m_size < DEPTH) exp_q.push_back(wr_data);
    end
  end

  always @(negedge clk) begin
    if (chk_on) begin
      check("send_req", {31'd0, send_req}, {31'd0, m_req});
      check("tx_byte", {24'd0, tx_byte}, {24'd0, m_byte});
      check("count", {27'd0, count}, exp_q.size());
      check("full", {31'd0, full}, {31'd0, exp_q.size() == DEPTH});
      check("empty", {31'd0, empty}, {31'd0, exp_q.size() == 0});
      check("overflow", {31'd0, overflow}, {31'd0, m_ovf});
    end
  end

  // ---------------- acknowledge responder ----------------
  logic ack_auto = 1'b0;
  logic ack_spur = 1'b0;
  logic man_ack  = 1'b0;
  logic req_seen = 1'b0;
  int   ack_min  = 0;
  int   ack_max  = 0;
  int   wait_cnt = 0;

  always @(posedge clk) begin
    #2;
    send_ack = man_ack;
    if (!send_req) begin
      req_seen = 1'b0;
    end else if (ack_auto) begin
      if (!req_seen) begin
        req_seen = 1'b1;
        wait_cnt = $urandom_range(ack_max, ack_min);
      end
      if (wait_cnt == 0) send_ack = 1'b1;
      else               wait_cnt--;
    end
    if (ack_spur && !send_req && $urandom_range(0, 2) == 0) send_ack = 1'b1;
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [7:0] d);
    wr_en   = 1'b1;
    wr_data = d;
    tick();
    wr_en   = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    tick();
  endtask

  task automatic wait_drain(input int limit);
    for (int i = 0; i < limit && (exp_q.size() != 0 || m_req); i++) tick();
    check("drain_in_time", {31'd0, exp_q.size() == 0 && !m_req}, 32'd1);
    tick();
    tick();
  endtask

  task automatic summary();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
  endtask

  initial begin
    #500000;
    n_fail++;
    $display("FAIL watchdog: simulation did not complete (t=%0t)", $time);
    summary();
    $finish;
  end

  // ---------------- tests ----------------
  logic [7:0] in_log[$];
  int         sent;

  initial begin
    reset = 1'b1;
    #1 chk_on = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    tick();
    check("rst_count", {27'd0, count}, 32'd0);
    check("rst_empty", {31'd0, empty}, 32'd1);
    check("rst_tx_byte", {24'd0, tx_byte}, 32'd0);

    // Single byte, ack 3 cycles into the request.
    ack_auto = 1'b1; ack_min = 3; ack_max = 3;
    out_log.delete();
    push(8'hA5);
    check("single_req_at_k", {31'd0, send_req}, 32'd0);
    tick();
    check("single_req_at_k1", {31'd0, send_req}, 32'd1);
    check("single_byte_at_k1", {24'd0, tx_byte}, 32'hA5);
    wait_drain(40);
    check("single_req_done", {31'd0, send_req}, 32'd0);
    check("single_count_done", {27'd0, count}, 32'd0);
    check("single_empty_done", {31'd0, empty}, 32'd1);
    check("single_out", {24'd0, out_log.size() > 0 ? out_log[0] : 8'h00}, 32'hA5);

    // Burst to full, then a rejected write on the same edge as an ack (with ovf_clr: set wins).
    ack_auto = 1'b0;
    out_log.delete();
    for (int i = 1; i <= 16; i++) push(8'(i));
    check("burst_count", {27'd0, count}, 32'd16);
    check("burst_full", {31'd0, full}, 32'd1);
    check("burst_no_ovf", {31'd0, overflow}, 32'd0);
    check("burst_head", {24'd0, tx_byte}, 32'h01);
    wr_en = 1'b1; wr_data = 8'hFF; man_ack = 1'b1; ovf_clr = 1'b1;
    tick();
    wr_en = 1'b0; man_ack = 1'b0;
    check("ovf_set_wins", {31'd0, overflow}, 32'd1);
    check("ovf_count", {27'd0, count}, 32'd15);
    check("ovf_not_full", {31'd0, full}, 32'd0);
    tick();
    ovf_clr = 1'b0;
    check("ovf_cleared", {31'd0, overflow}, 32'd0);
    pop_cyc.delete();
    ack_auto = 1'b1; ack_min = 0; ack_max = 0;
    wait_drain(200);
    check("burst_out_len", out_log.size(), 32'd16);
    for (int i = 0; i < 16 && i < out_log.size(); i++)
      check("burst_out_order", {24'd0, out_log[i]}, i + 1);
    for (int i = 1; i < pop_cyc.size(); i++)
      check("burst_pop_spacing", pop_cyc[i] - pop_cyc[i-1], 32'd3);

    // Simultaneous write and pop at count 5.
    ack_auto = 1'b0;
    out_log.delete();
    for (int i = 0; i < 5; i++) push(8'h21 + 8'(i));
    tick();
    check("simul_count_before", {27'd0, count}, 32'd5);
    wr_en = 1'b1; wr_data = 8'h26; man_ack = 1'b1;
    tick();
    wr_en = 1'b0; man_ack = 1'b0;
    check("simul_count_after", {27'd0, count}, 32'd5);
    ack_auto = 1'b1; ack_min = 0; ack_max = 2;
    wait_drain(200);
    check("simul_out_len", out_log.size(), 32'd6);
    for (int i = 0; i < 6 && i < out_log.size(); i++)
      check("simul_out_order", {24'd0, out_log[i]}, 32'h21 + i);

    // Asynchronous reset in the middle of a request, with overflow set.
    ack_auto = 1'b0;
    for (int i = 0; i < 17; i++) push(8'h40 + 8'(i));
    check("pre_rst_req", {31'd0, send_req}, 32'd1);
    check("pre_rst_ovf", {31'd0, overflow}, 32'd1);
    #2 reset = 1'b1;
    #1;
    check("arst_send_req", {31'd0, send_req}, 32'd0);
    check("arst_count", {27'd0, count}, 32'd0);
    check("arst_overflow", {31'd0, overflow}, 32'd0);
    check("arst_tx_byte", {24'd0, tx_byte}, 32'd0);
    tick();
    reset = 1'b0;
    tick();
    check("post_rst_empty", {31'd0, empty}, 32'd1);
    check("post_rst_req", {31'd0, send_req}, 32'd0);

    // Random wrap traffic: 40 bytes, ack delays 0..7, spurious acks outside requests.
    ack_auto = 1'b1; ack_min = 0; ack_max = 7; ack_spur = 1'b1;
    out_log.delete();
    in_log.delete();
    sent = 0;
    for (int c = 0; c < 3000 && sent < 40; c++) begin
      if ($urandom_range(0, 1) == 1 && exp_q.size() < DEPTH) begin
        wr_en   = 1'b1;
        wr_data = 8'($urandom);
        in_log.push_back(wr_data);
        sent++;
      end else begin
        wr_en = 1'b0;
      end
      tick();
    end
    wr_en = 1'b0;
    wait_drain(2000);
    ack_spur = 1'b0;
    check("wrap_out_len", out_log.size(), 32'd40);
    for (int i = 0; i < 40 && i < out_log.size(); i++)
      check("wrap_out_order", {24'd0, out_log[i]}, {24'd0, in_log[i]});
    check("wrap_no_ovf", {31'd0, overflow}, 32'd0);

    tick();
    summary();
    $finish;
  end

endmodule

// File: doc/uart_tx_fifo.md
Name: uart_tx_fifo

Overview:
Transmit-side buffer that sits directly upstream of the UART core. It accepts bytes from the host at up to one per clock, stores them in a circular FIFO, and presents them one at a time to the UART through the send_req/send_ack handshake. It decouples host write bursts from the serial line rate and reports fill level and overflow.

Parameters:
DEPTH, 16, number of byte entries; must be a power of two, minimum 2
ADDR_W, $clog2(DEPTH), pointer width; derived, never overridden

Ports:
clk  input  1  system clock; all state updates on the rising edge
reset  input  1  asynchronous, active-high; clears all state immediately
wr_en  input  1  host write strobe; sampled each rising edge
wr_data  input  8  host byte, valid when wr_en=1
full  output  1  combinational, 1 when count==DEPTH
empty  output  1  combinational, 1 when count==0
count  output  ADDR_W+1  registered number of stored bytes (0..DEPTH)
overflow  output  1  sticky; set when a write is rejected
ovf_clr  input  1  clears overflow on the next edge
tx_byte  output  8  registered byte driven to the UART data_in
send_req  output  1  registered request to the UART
send_ack  input  1  one-cycle acknowledge from the UART

Behaviour:
- Reset (asynchronous, while high): wr_ptr=0, rd_ptr=0, count=0, tx_byte=8'h00, send_req=0, overflow=0, state=IDLE. Memory contents are don't-care. Reset in mid-handshake drops send_req immediately and discards any queued bytes.
- Write: at an edge with wr_en=1 and full=0 (value before the edge), mem[wr_ptr]<=wr_data and wr_ptr increments modulo DEPTH.
- Rejected write: wr_en=1 with full=1 leaves memory unchanged and sets overflow. A same-edge pop does not make room for that write.
- overflow: ovf_clr=1 clears it. If ovf_clr and a rejected write occur at the same edge, set wins.
- count: +1 on an accepted write only, -1 on a pop only, unchanged when both occur at the same edge.
- Pointers wrap naturally at DEPTH.
- FSM states:
  - IDLE: if count!=0 at the edge, tx_byte<=mem[rd_ptr], send_req<=1, go to REQ.
  - REQ: hold send_req=1 and tx_byte stable. If send_ack=1 at the edge, pop (rd_ptr+1, count-1), send_req<=0, go to GAP.
  - GAP: one cycle with send_req=0, then go to IDLE.
- send_ack is ignored in IDLE and GAP.
- Latency: a write accepted at edge k into an empty FIFO gives send_req=1 after edge k+1.
- Between back-to-back bytes, send_req is low for exactly 2 cycles (GAP and IDLE).
- tx_byte only changes on the IDLE->REQ transition.
- Write to an empty FIFO while the FSM is in GAP: the byte is picked up in IDLE on the following cycle.
- count==DEPTH and DEPTH-1 boundaries must be exact; full and empty are never both 1.

Decomposition:
- Shared package uart_pkg: UART_DATA_W=8 and the FSM state enum typedef (IDLE, REQ, GAP), for reuse by the future RX-side FIFO.
- One natural sub-module: sync_fifo_mem, a DEPTH x 8 register array with one write port and an asynchronous read port.
- The FSM and pointer logic stay in uart_tx_fifo.

Test Plan:
- Reset: assert reset mid-REQ -> send_req, count, overflow and tx_byte go to 0 without waiting for a clock edge; after release, empty=1.
- Single byte: write 8'hA5 at edge k with the bench acking 3 cycles after send_req rises -> send_req=1 and tx_byte=8'hA5 after edge k+1; after the ack edge send_req=0, count=0, empty=1.
- Burst: write 8'h01..8'h10 on 16 consecutive cycles, DEPTH=16 -> full=1, count=16, no overflow; the acked sequence out is 01..10 in order with 2-cycle send_req gaps.
- Overflow: with the FIFO full, write 8'hFF at the same edge as an ack -> write rejected, overflow=1, count=15, and 8'hFF never appears on tx_byte; ovf_clr clears overflow.
- Simultaneous: count=5, write and ack at the same edge -> count stays 5, and the written byte is transmitted after the existing 4.
- Wrap: push and pop 40 bytes with random ack delays (0..7 cycles) -> output matches input order, pointers wrap twice, and a spurious send_ack in GAP/IDLE causes no extra pop.
